// File: rtl/complex_op_stream_gen.sv
// complex_op_stream_gen
//   Operand-stream generator for the complex multiplier. Drives (op_1, op_2)
//   operand pairs over a valid/ready handshake in constant, incrementing or
//   LFSR pattern mode, for a run of num_ops transactions started by start.
//
//   Optional build macro: COMPLEX_STREAM_GAP_EN
//     defined   -> op_val drops for one cycle after every non-final accept
//     undefined -> back-to-back transfers, one per cycle
//
//   Ports:
//     clk, rst            clock, async active-high reset
//     sw_rst              sync software reset (same effect as rst)
//     start, mode,        run control; mode/num_ops sampled on start in IDLE
//     num_ops
//     op_ready / op_val   handshake with the multiplier
//     op_1_re .. op_2_im  operand fields
//     busy, done          run in progress / one-cycle end-of-run pulse
//     sent_cnt            transactions accepted in the current/last run
module complex_op_stream_gen #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 8,
    parameter int unsigned OP_1_RE    = 2,
    parameter int unsigned OP_1_IM    = 4,
    parameter int unsigned OP_2_RE    = 3,
    parameter int unsigned OP_2_IM    = 6,
    parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sw_rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [CNT_WIDTH-1:0]  num_ops,
    input  logic                  op_ready,
    output logic                  op_val,
    output logic [DATA_WIDTH-1:0] op_1_re,
    output logic [DATA_WIDTH-1:0] op_1_im,
    output logic [DATA_WIDTH-1:0] op_2_re,
    output logic [DATA_WIDTH-1:0] op_2_im,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  sent_cnt
);

    typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

    localparam logic [31:0] LFSR_TAPS = 32'hA300_0000;

    // Field order in the packed arrays: 0=op_1_re, 1=op_1_im, 2=op_2_re, 3=op_2_im
    localparam logic [3:0][31:0] SEEDS = {LFSR_SEED + 32'd3, LFSR_SEED + 32'd2,
                                          LFSR_SEED + 32'd1, LFSR_SEED};
    localparam logic [3:0][DATA_WIDTH-1:0] OP_INIT = {DATA_WIDTH'(OP_2_IM), DATA_WIDTH'(OP_2_RE),
                                                      DATA_WIDTH'(OP_1_IM), DATA_WIDTH'(OP_1_RE)};

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    state_t                      state_q, state_d;
    logic [1:0]                  mode_q, mode_d;
    logic [CNT_WIDTH-1:0]        num_q, num_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d, cnt_inc;
    logic                        gap_q, gap_d;
    logic [3:0][DATA_WIDTH-1:0]  ops_q, ops_d;
    logic [3:0][31:0]            lfsr_q, lfsr_d;
    logic                        accept;

    assign op_val   = (state_q == SEND) && !gap_q;
    assign busy     = (state_q == SEND);
    assign done     = (state_q == FIN);
    assign sent_cnt = cnt_q;
    assign op_1_re  = ops_q[0];
    assign op_1_im  = ops_q[1];
    assign op_2_re  = ops_q[2];
    assign op_2_im  = ops_q[3];
    assign accept   = op_val && op_ready;
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        gap_d   = 1'b0;
        ops_d   = ops_q;
        lfsr_d  = lfsr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    num_d  = num_ops;
                    cnt_d  = '0;
                    lfsr_d = SEEDS;
                    for (int unsigned k = 0; k < 4; k++) begin
                        ops_d[k] = (mode == 2'd2) ? SEEDS[k][DATA_WIDTH-1:0] : OP_INIT[k];
                    end
                    state_d = (num_ops == '0) ? FIN : SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == num_q) begin
                        state_d = FIN;
                    end else begin
`ifdef COMPLEX_STREAM_GAP_EN
                        gap_d = 1'b1;
`endif
                        for (int unsigned k = 0; k < 4; k++) begin
                            if (mode_q == 2'd1) begin
                                ops_d[k] = ops_q[k] + 1'b1;
                            end else if (mode_q == 2'd2) begin
                                lfsr_d[k] = lfsr_step(lfsr_q[k]);
                                ops_d[k]  = lfsr_d[k][DATA_WIDTH-1:0];
                            end
                        end
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Software reset folded into next-state so the register process
        // only carries the asynchronous reset.
        if (sw_rst) begin
            state_d = IDLE;
            mode_d  = '0;
            num_d   = '0;
            cnt_d   = '0;
            gap_d   = 1'b0;
            ops_d   = OP_INIT;
            lfsr_d  = SEEDS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= 1'b0;
            ops_q   <= OP_INIT;
            lfsr_q  <= SEEDS;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            ops_q   <= ops_d;
            lfsr_q  <= lfsr_d;
        end
    end

endmodule
